// File: rtl/packet_framer_tx.sv
// Response packet framer: serialises SYNC, LEN, OPCODE, payload and CRC-8
// onto the uart_core TX byte interface, one latched request at a time.
module packet_framer_tx #(
  parameter int         MAX_PAYLOAD = 16,
  parameter logic [7:0] SYNC        = 8'hAA,
  parameter logic [7:0] CRC_POLY    = 8'h07,
  parameter logic [7:0] CRC_INIT    = 8'h00
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [7:0]               req_opcode,
  input  logic [7:0]               req_len,
  input  logic [8*MAX_PAYLOAD-1:0] req_payload,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic                     err_len
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // tx_valid/tx_data hold until consumed; req_ready comes only from state.

  localparam int         IDX_W   = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_LEN, S_OPC, S_PAY, S_CRC
  } state_t;

  state_t     state, state_next;
  logic [7:0] op_r;
  logic [7:0] len_r;
  logic [7:0] cnt;
  logic [7:0] crc;
  logic [7:0] pay_mem [MAX_PAYLOAD];
  logic       accept;
  logic       consume;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int k = 0; k < 8; k++) begin
      r = r[7] ? ((r << 1) ^ CRC_POLY) : (r << 1);
    end
    return r;
  endfunction

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign tx_valid  = (state != S_IDLE);
  assign accept    = req_valid && req_ready;
  assign consume   = tx_valid && tx_ready;

  always_comb begin
    state_next = state;
    tx_data    = 8'h00;
    case (state)
      S_IDLE: begin
        if (accept && (req_len <= MAX_LEN)) state_next = S_SYNC;
      end
      S_SYNC: begin
        tx_data = SYNC;
        if (consume) state_next = S_LEN;
      end
      S_LEN: begin
        tx_data = len_r + 8'd1;
        if (consume) state_next = S_OPC;
      end
      S_OPC: begin
        tx_data = op_r;
        if (consume) state_next = (len_r != 8'd0) ? S_PAY : S_CRC;
      end
      S_PAY: begin
        tx_data = pay_mem[cnt[IDX_W-1:0]];
        if (consume && (cnt == len_r - 8'd1)) state_next = S_CRC;
      end
      S_CRC: begin
        tx_data = crc;
        if (consume) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state   <= S_IDLE;
      err_len <= 1'b0;
      op_r    <= 8'h00;
      len_r   <= 8'h00;
      cnt     <= 8'h00;
      crc     <= CRC_INIT;
    end else begin
      state   <= state_next;
      err_len <= accept && (req_len > MAX_LEN);
      if (accept) begin
        op_r  <= req_opcode;
        len_r <= req_len;
        cnt   <= 8'h00;
        crc   <= CRC_INIT;
        for (int i = 0; i < MAX_PAYLOAD; i++) begin
          pay_mem[i] <= req_payload[8*i +: 8];
        end
      end
      // CRC folds in each covered byte as it leaves, so it is final on entry to S_CRC.
      if (consume && (state == S_LEN || state == S_OPC || state == S_PAY)) begin
        crc <= crc_step(crc, tx_data);
      end
      if (consume && state == S_PAY) cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_packet_framer_tx.sv
// Directed bench for packet_framer_tx: table of frame requests with expected
// byte streams, plus hand-written length-error and mid-frame reset sequences.
module tb_packet_framer_tx;

  localparam int MAXP = 16;

  logic              CLK;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [7:0]        req_opcode;
  logic [7:0]        req_len;
  logic [8*MAXP-1:0] req_payload;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              err_len;

  packet_framer_tx #(.MAX_PAYLOAD(MAXP)) dut (
    .CLK(CLK), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_len(req_len), .req_payload(req_payload),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .err_len(err_len)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] opcode;
    logic [7:0] len;
    logic [7:0] pay_base;
    logic [7:0] pay_step;
    int         ready_pct;
    logic       crc_known;
    logic [7:0] exp_crc;
    logic       mess;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] exp_q [$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int k = 0; k < 8; k++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  task automatic load_req(input vec_t v);
    req_opcode = v.opcode;
    req_len    = v.len;
    for (int i = 0; i < MAXP; i++) req_payload[8*i +: 8] = 8'(int'(v.pay_base) + i * int'(v.pay_step));
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0] crc;
    logic [7:0] b;
    logic       prev_hold;
    logic [7:0] prev_data;
    int         cycles;
    int         waits;
    waits = 0;
    while (!req_ready && waits < 20) begin
      @(negedge CLK);
      waits++;
    end
    check8("req_ready_before_req", {7'd0, req_ready}, 8'd1);
    exp_q = {};
    exp_q.push_back(8'hAA);
    crc = 8'h00;
    b = v.len + 8'd1;
    exp_q.push_back(b);
    crc = crc_ref(crc, b);
    exp_q.push_back(v.opcode);
    crc = crc_ref(crc, v.opcode);
    for (int i = 0; i < int'(v.len); i++) begin
      b = 8'(int'(v.pay_base) + i * int'(v.pay_step));
      exp_q.push_back(b);
      crc = crc_ref(crc, b);
    end
    exp_q.push_back(v.crc_known ? v.exp_crc : crc);

    load_req(v);
    req_valid = 1'b1;
    tx_ready  = 1'b0;
    @(negedge CLK);
    req_valid = 1'b0;
    check8("busy_after_accept", {7'd0, busy}, 8'd1);
    check8("req_ready_after_accept", {7'd0, req_ready}, 8'd0);

    prev_hold = 1'b0;
    prev_data = 8'h00;
    cycles    = 0;
    while (exp_q.size() > 0 && cycles < 400) begin
      if (v.mess && cycles == 2) begin
        req_valid   = 1'b1;
        req_payload = ~req_payload;
        req_opcode  = 8'hEE;
        req_len     = 8'd3;
      end
      if (v.mess && exp_q.size() <= 1) req_valid = 1'b0;
      if (v.mess && req_valid) check8("req_ready_held_off", {7'd0, req_ready}, 8'd0);
      tx_ready = (int'($urandom_range(99)) < v.ready_pct);
      check8("tx_valid_in_frame", {7'd0, tx_valid}, 8'd1);
      if (prev_hold) check8("tx_data_stable", tx_data, prev_data);
      if (tx_valid && tx_ready) check8("tx_byte", tx_data, exp_q.pop_front());
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
      @(negedge CLK);
      cycles++;
    end
    if (cycles >= 400) check8("frame_timeout", 8'd1, 8'd0);
    req_valid = 1'b0;
    check8("tx_valid_after_frame", {7'd0, tx_valid}, 8'd0);
    check8("req_ready_after_frame", {7'd0, req_ready}, 8'd1);
    check8("busy_after_frame", {7'd0, busy}, 8'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{8'h07, 8'd0,  8'h00, 8'h00, 100, 1'b1, 8'h00, 1'b0};
    vecs[1] = '{8'h07, 8'd1,  8'h12, 8'h00, 100, 1'b1, 8'hC3, 1'b0};
    vecs[2] = '{8'h07, 8'd1,  8'h12, 8'h00, 30,  1'b1, 8'hC3, 1'b0};
    vecs[3] = '{8'h21, 8'd16, 8'h00, 8'h01, 100, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h3C, 8'd5,  8'hA0, 8'h07, 50,  1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h00, 8'd2,  8'hFF, 8'h00, 100, 1'b0, 8'h00, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_opcode = 8'h00; req_len = 8'h00;
    req_payload = '0; tx_ready = 1'b0;
    repeat (3) @(negedge CLK);
    check8("rst_tx_valid", {7'd0, tx_valid}, 8'd0);
    check8("rst_req_ready", {7'd0, req_ready}, 8'd1);
    check8("rst_busy", {7'd0, busy}, 8'd0);
    check8("rst_err_len", {7'd0, err_len}, 8'd0);
    check8("rst_tx_data", tx_data, 8'h00);
    rst = 1'b0;
    @(negedge CLK);

    for (int n = 0; n < 6; n++) run_frame(vecs[n]);

    // Over-length request: nothing sent, single err_len pulse.
    req_opcode = 8'h07; req_len = 8'd17; req_valid = 1'b1; tx_ready = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    check8("errlen_pulse", {7'd0, err_len}, 8'd1);
    check8("errlen_tx_valid", {7'd0, tx_valid}, 8'd0);
    check8("errlen_req_ready", {7'd0, req_ready}, 8'd1);
    @(negedge CLK);
    check8("errlen_one_cycle", {7'd0, err_len}, 8'd0);
    check8("errlen_tx_valid_2", {7'd0, tx_valid}, 8'd0);
    check8("errlen_busy", {7'd0, busy}, 8'd0);

    // Reset while in the payload phase aborts the frame.
    load_req('{8'h44, 8'd8, 8'h30, 8'h01, 100, 1'b0, 8'h00, 1'b0});
    req_valid = 1'b1; tx_ready = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    repeat (5) @(negedge CLK);
    check8("pay_busy", {7'd0, busy}, 8'd1);
    check8("pay_byte2", tx_data, 8'h32);
    rst = 1'b1; tx_ready = 1'b0;
    @(negedge CLK);
    check8("abort_tx_valid", {7'd0, tx_valid}, 8'd0);
    check8("abort_busy", {7'd0, busy}, 8'd0);
    check8("abort_req_ready", {7'd0, req_ready}, 8'd1);
    rst = 1'b0;
    @(negedge CLK);
    run_frame(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_framer_tx.md
Name: packet_framer_tx

Overview:
Builds response packets and sends them to the PC one byte at a time. It is the transmit counterpart of the receive packet assembler and uses the same frame format: SYNC, LEN, OPCODE, payload bytes, then a CRC byte. Command blocks (status, readback, error reports) hand it one request at a time. It drives the uart_core TX byte interface (tx_data / tx_valid / tx_ready).

Parameters:
- MAX_PAYLOAD, 16, maximum number of payload bytes per frame (1..252).
- SYNC, 8'hAA, first byte of every frame.
- CRC_POLY, 8'h07, CRC-8 polynomial, processed MSB-first.
- CRC_INIT, 8'h00, CRC register value at the start of each frame.

Ports:
- CLK  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  a frame request is present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_opcode  in  8  opcode byte to send.
- req_len  in  8  number of payload bytes, 0..MAX_PAYLOAD.
- req_payload  in  8*MAX_PAYLOAD  payload; byte i = req_payload[8*i +: 8].
- tx_data  out  8  byte to uart_core.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  uart_core accepts the byte.
- busy  out  1  a frame is in progress (state != IDLE).
- err_len  out  1  one-cycle pulse when a request has req_len > MAX_PAYLOAD.

Behaviour:
- Reset values: req_ready=1, tx_valid=0, tx_data=8'h00, busy=0, err_len=0; state=IDLE.
- Reset during a frame aborts it on the next edge: tx_valid=0 and the partial frame is not resumed.
- Request accept happens when req_valid && req_ready at a rising edge.
  - On accept, latch opcode, length and payload into internal registers; later changes on the req_* inputs are ignored.
  - req_ready is registered and never depends combinationally on tx_ready.
- Length error: if the accepted req_len > MAX_PAYLOAD, send nothing, pulse err_len for exactly one cycle (the cycle after accept), and stay in IDLE.
- Byte handshake: a byte is consumed on any edge where tx_valid && tx_ready.
  - tx_data and tx_valid stay stable until the byte is consumed.
  - tx_valid never drops without a consume, except on reset.
- States: IDLE -> SYNC -> LEN -> OPC -> PAY -> CRC -> IDLE.
  - IDLE: on a valid accept, go to SYNC; tx_valid=1 and tx_data=SYNC from the cycle after accept.
  - SYNC: on consume, go to LEN; tx_data = req_len+1 (opcode plus payload count).
  - LEN: on consume, go to OPC; tx_data = opcode.
  - OPC: on consume, go to PAY if len>0, otherwise to CRC.
  - PAY: send bytes 0..len-1 in ascending index order using a byte counter. After byte len-1 is consumed, go to CRC.
  - CRC: tx_data = the final CRC. On consume, set tx_valid=0 and go to IDLE; req_ready=1 on the following cycle.
- CRC calculation:
  - Covers the LEN, OPCODE and payload bytes; SYNC and the CRC byte itself are excluded.
  - At accept, crc=CRC_INIT.
  - For each covered byte, on its consume: crc ^= byte, then 8 times: crc = crc[7] ? (crc<<1)^CRC_POLY : crc<<1, truncated to 8 bits.
  - The CRC byte must already be correct in the first cycle of the CRC state.
- Throughput: with tx_ready held high, one byte goes out per cycle and the frame length is len+4 bytes. There is at least one idle cycle between frames.
- If req_valid arrives while busy, it is held off (req_ready=0); there is no queueing.

Test Plan:
1. After reset, check that tx_valid=0 and req_ready=1. Request opcode=0x07, len=0, with tx_ready=1 -> tx bytes AA 01 07 00, then tx_valid=0 and req_ready=1 one cycle later.
2. Request opcode=0x07, len=1, payload[0]=0x12 -> bytes AA 02 07 12 C3.
3. Toggle tx_ready randomly (30% high) during the test 2 frame -> tx_data stays stable while tx_valid=1 && !tx_ready, and the byte sequence is identical to test 2.
4. Request len=MAX_PAYLOAD=16 with payload i = i -> 20 bytes, payload 00..0F in order, CRC matching the reference model. Then request len=17 -> err_len pulses once, no tx_valid, req_ready back high.
5. Change req_payload and req_valid mid-frame -> transmitted bytes still match the latched request and no second frame starts until IDLE.
6. Assert rst while in the PAY state -> the next cycle has tx_valid=0, busy=0 and req_ready=1. A new request sends a complete, correct frame starting with AA.
